inv_nch_filt: RTL and testbench
===============================

INV_NCH_FILT -- requirements
Module: inv_nch_filt

Interface
REQ-001 The block SHALL have parameter CH, default 6, giving the number of independent inverter channels (1..32).
REQ-002 The block SHALL have parameter FILT_CYCLES, default 4, giving the consecutive stable cycles required to accept an input change (1..255).
REQ-003 The block SHALL have port clk, input, 1 bit: the single rising-edge clock.
REQ-004 The block SHALL have port rst_n, input, 1 bit: the reset, which is asynchronous and active-low.
REQ-005 The block SHALL have port en, input, 1 bit: filter enable; 0 freezes all channels.
REQ-006 The block SHALL have port a, input, CH bits: asynchronous channel inputs; bit i is channel i.
REQ-007 The block SHALL have port y, output, CH bits: inverted filtered outputs.
REQ-008 The block SHALL have port chg, output, CH bits: one-cycle pulse on the cycle after y[i] changes.

Function
REQ-009 Each channel SHALL pass a[i] through a 2-flop synchroniser, producing s[i].
REQ-010 Each channel SHALL hold a filtered state f[i] and a counter cnt[i] of width clog2(FILT_CYCLES+1).
REQ-011 When en=1 and s[i]==f[i], cnt[i] SHALL clear to 0 on the next edge.
REQ-012 When en=1, s[i]!=f[i] and cnt[i]<FILT_CYCLES-1, cnt[i] SHALL increment on the next edge.
REQ-013 When en=1, s[i]!=f[i] and cnt[i]==FILT_CYCLES-1, f[i] SHALL take s[i] and cnt[i] SHALL clear on the same edge.
REQ-014 With FILT_CYCLES=1, f[i] SHALL follow s[i] one edge later with no filtering.
REQ-015 A clean input step SHALL reach y exactly 2+FILT_CYCLES rising edges after the first edge sampling the new level.
REQ-016 An input pulse shorter than FILT_CYCLES cycles at s[i] SHALL leave f[i] and y[i] unchanged and cnt[i] back at 0.
REQ-017 When en=0, f[i] SHALL hold, cnt[i] SHALL be forced to 0 and chg SHALL be 0; the synchronisers SHALL keep sampling.
REQ-018 When en rises, filtering SHALL restart from cnt=0, so the full FILT_CYCLES stability window applies.
REQ-019 y[i] SHALL equal ~f[i], subject to REQ-024.
REQ-020 chg[i] SHALL be registered and SHALL be high for exactly one cycle, starting on the edge after f[i] toggles.
REQ-021 Channels SHALL be fully independent; simultaneous changes on several channels SHALL each follow REQ-011..020.

Reset
REQ-022 While rst_n=0, all sync flops, f, cnt and chg SHALL be 0, giving y all-ones (or Z per REQ-024), asynchronously.
REQ-023 Reset asserted mid-count SHALL discard the partial count; after release, a held input needs the full 2+FILT_CYCLES cycles to reach y.

Configuration
REQ-024 With macro INV_OPEN_DRAIN_EN defined, y[i] SHALL be driven 0 when f[i]=1 and high-impedance when f[i]=0, modelling an open-collector output; without it, y[i] SHALL be a push-pull ~f[i].

Structure
REQ-025 Package inv_pkg SHALL hold INV_CH_DEFAULT=6, INV_FILT_DEFAULT=4 and the counter-width function.
REQ-026 One sub-module, inv_filt_ch, SHALL implement a single channel (synchroniser, counter, f, chg); the top SHALL instantiate CH copies and apply the output stage.

Verification
REQ-027 CH=6, FILT=4, push-pull: reset, a=6'h00 -> y=6'h3F, chg=0.
REQ-028 a: 6'h00 -> 6'h01 held -> y[0] falls 6 edges later, chg[0] pulses once on the next cycle, y[5:1] stay 1.
REQ-029 a[1] high for 3 cycles, then low -> y stays 6'h3F, chg stays 0.
REQ-030 a: 6'h00 -> 6'h3F on one cycle -> y=6'h00 after 6 edges, chg=6'h3F for one cycle.
REQ-031 en=0, a: 6'h00 -> 6'h04 held 10 cycles -> y unchanged; then en=1 -> y[2] falls 4 edges later.
REQ-032 Drive a[3]=1 for 2 edges, pulse rst_n low for 1 cycle -> y=6'h3F immediately; y[3] falls 6 edges after release.
REQ-033 INV_OPEN_DRAIN_EN defined, a=6'h01 settled -> y=6'bZZZZZ0.

Source files
------------

// File: rtl/inv_nch_filt_pkg.sv
// Shared defaults and the counter-width helper for the multi-channel inverter filter.
package inv_pkg;

   localparam int INV_CH_DEFAULT   = 6;
   localparam int INV_FILT_DEFAULT = 4;

   // Wide enough to hold 0..filt_cycles.
   function automatic int inv_cnt_width(input int filt_cycles);
      return (filt_cycles < 1) ? 1 : $clog2(filt_cycles + 1);
   endfunction

endpackage

// File: rtl/inv_nch_filt_ch.sv
// Single filter channel: 2-flop synchroniser, stability counter, filtered state and
// a registered one-cycle change pulse.
module inv_filt_ch
   import inv_pkg::*;
#(
   parameter int FILT_CYCLES = INV_FILT_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic a,
   output logic f,
   output logic chg
);

   localparam int CW = inv_cnt_width(FILT_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYCLES - 1);

   logic          s_meta;
   logic          s;
   logic          f_d;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_meta <= 1'b0;
         s      <= 1'b0;
         f      <= 1'b0;
         f_d    <= 1'b0;
         cnt    <= '0;
         chg    <= 1'b0;
      end else begin
         s_meta <= a;
         s      <= s_meta;
         f_d    <= f;
         if (!en) begin
            cnt <= '0;
            chg <= 1'b0;
         end else begin
            // f_d lags f by one edge, so the pulse lands on the edge after the toggle.
            chg <= f ^ f_d;
            if (s == f) begin
               cnt <= '0;
            end else if (cnt == CNT_LAST) begin
               f   <= s;
               cnt <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/inv_nch_filt.sv
// Multi-channel debounced inverter. Define INV_OPEN_DRAIN_EN for an open-collector
// output stage (drive 0 or release to Z); default is push-pull.
module inv_nch_filt
   import inv_pkg::*;
#(
   parameter int CH          = INV_CH_DEFAULT,
   parameter int FILT_CYCLES = INV_FILT_DEFAULT
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic [CH-1:0] a,
   output logic [CH-1:0] y,
   output logic [CH-1:0] chg
);

   logic [CH-1:0] f;

   for (genvar i = 0; i < CH; i++) begin : g_ch
      inv_filt_ch #(
         .FILT_CYCLES(FILT_CYCLES)
      ) u_ch (
         .clk   (clk),
         .rst_n (rst_n),
         .en    (en),
         .a     (a[i]),
         .f     (f[i]),
         .chg   (chg[i])
      );

`ifdef INV_OPEN_DRAIN_EN
      assign y[i] = f[i] ? 1'b0 : 1'bz;
`else
      assign y[i] = ~f[i];
`endif
   end

endmodule

// File: tb/tb_inv_nch_filt.sv
// Directed bench for inv_nch_filt: a vector table for the main sequence plus
// hand-written reset-mid-count and FILT_CYCLES=1 sequences.
module tb_inv_nch_filt;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic [5:0] a;
   logic [5:0] y;
   logic [5:0] chg;

   logic [1:0] a1;
   logic [1:0] y1;
   logic [1:0] chg1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   inv_nch_filt #(.CH(6), .FILT_CYCLES(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .a     (a),
      .y     (y),
      .chg   (chg)
   );

   inv_nch_filt #(.CH(2), .FILT_CYCLES(1)) dut_f1 (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .a     (a1),
      .y     (y1),
      .chg   (chg1)
   );

   typedef struct {
      logic [5:0] a;
      logic       en;
      int         n;
      logic [5:0] exp_y;
      logic [5:0] exp_chg;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic [5:0] va, input logic ven, input int vn,
                      input logic [5:0] vy, input logic [5:0] vc);
      vec_t v;
      v.a = va; v.en = ven; v.n = vn; v.exp_y = vy; v.exp_chg = vc;
      vecs.push_back(v);
   endtask

   task automatic run(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      en    = 1'b1;
      a     = 6'h00;
      a1    = 2'b00;

      // Reset state, asynchronously before any clock edge.
      #2;
      chk("reset_y", y, 6'h3F);
      chk("reset_chg", chg, 6'h00);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // a, en, edges, expected y, expected chg
      add(6'h00, 1'b1, 3, 6'h3F, 6'h00);
      add(6'h01, 1'b1, 5, 6'h3F, 6'h00);   // one edge short of the step latency
      add(6'h01, 1'b1, 1, 6'h3E, 6'h00);   // y[0] falls on edge 6
      add(6'h01, 1'b1, 1, 6'h3E, 6'h01);   // chg pulses the cycle after
      add(6'h01, 1'b1, 1, 6'h3E, 6'h00);
      add(6'h03, 1'b1, 3, 6'h3E, 6'h00);   // 3-cycle glitch on a[1]
      add(6'h01, 1'b1, 6, 6'h3E, 6'h00);   // glitch rejected
      add(6'h00, 1'b1, 8, 6'h3F, 6'h00);
      add(6'h3F, 1'b1, 5, 6'h3F, 6'h00);
      add(6'h3F, 1'b1, 1, 6'h00, 6'h00);   // all channels switch together
      add(6'h3F, 1'b1, 1, 6'h00, 6'h3F);
      add(6'h3F, 1'b1, 1, 6'h00, 6'h00);
      add(6'h00, 1'b1, 8, 6'h3F, 6'h00);
      add(6'h04, 1'b0, 10, 6'h3F, 6'h00);  // frozen while disabled
      add(6'h04, 1'b1, 3, 6'h3F, 6'h00);   // full window restarts on enable
      add(6'h04, 1'b1, 1, 6'h3B, 6'h00);
      add(6'h04, 1'b1, 1, 6'h3B, 6'h04);
      add(6'h00, 1'b1, 8, 6'h3F, 6'h00);

      for (int i = 0; i < vecs.size(); i++) begin
         a  = vecs[i].a;
         en = vecs[i].en;
         run(vecs[i].n);
         chk($sformatf("vec%0d_y", i), y, vecs[i].exp_y);
         chk($sformatf("vec%0d_chg", i), chg, vecs[i].exp_chg);
      end

      // Reset in the middle of a count discards the partial progress.
      a = 6'h08;
      run(2);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_y", y, 6'h3F);
      chk("rst_mid_chg", chg, 6'h00);
      @(negedge clk);
      rst_n = 1'b1;
      run(5);
      chk("rst_rel_y5", y, 6'h3F);
      run(1);
      chk("rst_rel_y6", y, 6'h37);
      run(1);
      chk("rst_rel_chg", chg, 6'h08);

      // FILT_CYCLES=1: no filtering, step reaches y after 3 edges.
      a1 = 2'b10;
      run(2);
      chk("f1_y2", {4'h0, y1}, 6'h03);
      run(1);
      chk("f1_y3", {4'h0, y1}, 6'h01);
      run(1);
      chk("f1_chg", {4'h0, chg1}, 6'h02);
      a1 = 2'b00;
      run(1);
      chk("f1_chg_off", {4'h0, chg1}, 6'h00);
      run(2);
      chk("f1_back", {4'h0, y1}, 6'h03);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
